// File: rtl/softmax_max_sub_pkg.sv
// Shared constants and types for the softmax max-subtract front end.
package softmax_max_sub_pkg;

    localparam int DATA_W      = 18;   // signed S7Q10 score width
    localparam int FRAC_W      = 10;   // fractional bits of S7Q10
    localparam int ROW_LEN_MAX = 64;   // deepest row the buffer holds
    localparam int ADDR_W      = 6;    // log2(ROW_LEN_MAX)

    // Most negative representable S7Q10 value; floor of every x - max result.
    localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EMIT = 2'd2
    } state_t;

endpackage

// File: rtl/softmax_row_buf.sv
// One-row score buffer: single synchronous write port, asynchronous read port.
// Storage is never reset; every slot read is written earlier in the same row.
module softmax_row_buf #(
    parameter int DATA_W = softmax_max_sub_pkg::DATA_W,
    parameter int DEPTH  = softmax_max_sub_pkg::ROW_LEN_MAX,
    parameter int ADDR_W = softmax_max_sub_pkg::ADDR_W
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [ADDR_W-1:0]        waddr_i,
    input  logic signed [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0]        raddr_i,
    output logic signed [DATA_W-1:0] rdata_o
);

    logic signed [DATA_W-1:0] mem_q [DEPTH];

    // Capture one score per accepted input beat.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/softmax_max_sub.sv
// Softmax front end: buffers a row of S7Q10 scores while tracking the row
// maximum, then replays the row as sat(x - max) so the exp stage only ever
// sees values <= 0. Ready/valid on both sides, one row in flight at a time.
module softmax_max_sub #(
    parameter int DATA_W      = softmax_max_sub_pkg::DATA_W,
    parameter int ROW_LEN_MAX = softmax_max_sub_pkg::ROW_LEN_MAX,
    parameter int ADDR_W      = softmax_max_sub_pkg::ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDR_W:0]          row_len,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_last,
    output logic                     busy
);

    import softmax_max_sub_pkg::*;

    localparam logic [ADDR_W:0] LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(ROW_LEN_MAX);
    // -2^(DATA_W-1) expressed at the widened difference width.
    localparam logic signed [DATA_W:0] DIFF_LO = {2'b11, {(DATA_W-1){1'b0}}};

    // Row length 0 means a single element; anything above the buffer depth
    // is truncated to a full buffer.
    function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] l);
        if (l == '0) begin
            return LEN_ONE;
        end else if (l > LEN_MAX) begin
            return LEN_MAX;
        end
        return l;
    endfunction

    // x - max is never positive, so only the negative rail needs clamping.
    function automatic logic signed [DATA_W-1:0] sat_diff(input logic signed [DATA_W:0] d);
        if (d < DIFF_LO) begin
            return DIFF_LO[DATA_W-1:0];
        end
        return d[DATA_W-1:0];
    endfunction

    state_t                   state_q, state_d;
    logic [ADDR_W:0]          len_q, len_d;
    logic [ADDR_W:0]          wr_cnt_q, wr_cnt_d;
    logic [ADDR_W:0]          rd_cnt_q, rd_cnt_d;
    logic signed [DATA_W-1:0] max_q, max_d;
    logic signed [DATA_W-1:0] out_data_q, out_data_d;
    logic                     out_valid_q, out_valid_d;
    logic                     out_last_q, out_last_d;
    logic                     in_ready_q, in_ready_d;

    logic                     accept;
    logic                     out_fire;
    logic                     emit_load;
    logic [ADDR_W:0]          len_in;
    logic signed [DATA_W-1:0] rd_data;
    logic signed [DATA_W:0]   diff;

    assign accept    = in_valid && in_ready_q;
    assign out_fire  = out_valid_q && out_ready;
    assign emit_load = (state_q == EMIT) && (!out_valid_q || out_ready) && (rd_cnt_q < len_q);
    assign len_in    = clamp_len(row_len);
    assign diff      = {rd_data[DATA_W-1], rd_data} - {max_q[DATA_W-1], max_q};

    softmax_row_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (ROW_LEN_MAX),
        .ADDR_W (ADDR_W)
    ) u_row_buf (
        .clk_i   (clk),
        .we_i    (accept),
        .waddr_i (wr_cnt_q[ADDR_W-1:0]),
        .wdata_i (in_data),
        .raddr_i (rd_cnt_q[ADDR_W-1:0]),
        .rdata_o (rd_data)
    );

    // State, counters, running max and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            len_q       <= '0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            max_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            max_q       <= max_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // Next-state: load the row and its max, then drain it through the output register.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        max_d       = max_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    len_d    = len_in;
                    max_d    = in_data;
                    wr_cnt_d = LEN_ONE;
                    state_d  = (len_in == LEN_ONE) ? EMIT : LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    max_d    = (in_data > max_q) ? in_data : max_q;
                    wr_cnt_d = wr_cnt_q + LEN_ONE;
                    if ((wr_cnt_q + LEN_ONE) == len_q) begin
                        state_d = EMIT;
                    end
                end
            end
            EMIT: begin
                if (emit_load) begin
                    out_data_d  = sat_diff(diff);
                    out_last_d  = (rd_cnt_q == (len_q - LEN_ONE));
                    out_valid_d = 1'b1;
                    rd_cnt_d    = rd_cnt_q + LEN_ONE;
                end else if (out_fire) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end
                // Final handshake of the row: return to IDLE with clean counters.
                if (out_fire && out_last_q) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    rd_cnt_d    = '0;
                    wr_cnt_d    = '0;
                    max_d       = '0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered so that in_ready is low in reset and rises the cycle after the row drains.
        in_ready_d = (state_d != EMIT);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_softmax_max_sub.sv
// Bench for softmax_max_sub: random rows, scoreboard fed by a plain-arithmetic
// row model, and a monitor that checks every output handshake and stall.
module tb_softmax_max_sub;

    localparam int DW   = softmax_max_sub_pkg::DATA_W;
    localparam int AW   = softmax_max_sub_pkg::ADDR_W;
    localparam int LMAX = softmax_max_sub_pkg::ROW_LEN_MAX;
    localparam int RLW  = AW + 1;
    localparam int SATV = int'(softmax_max_sub_pkg::SAT_MIN);

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [AW:0]          row_len;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_data;
    logic                 out_last;
    logic                 busy;

    typedef struct {
        int data;
        bit last;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   rv[LMAX];
    int   rdy_mode = 0;

    softmax_max_sub dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_len   (row_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Downstream ready: 0 = always ready, 1 = random, 2 = forced stall.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on each handshake and checks stall stability.
    initial begin
        bit   pv = 1'b0;
        bit   ps = 1'b0;
        bit   pl = 1'b0;
        int   pd = 0;
        int   acc_edge = -10;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                pv = 1'b0;
                ps = 1'b0;
            end else begin
                if (ps) begin
                    chk("hold_valid", int'(out_valid), 1);
                    chk("hold_data", int'(out_data), pd);
                    chk("hold_last", int'(out_last), int'(pl));
                end
                if (out_valid && !pv) begin
                    chk("first_out_latency", cyc, acc_edge + 1);
                end
                if (out_valid) begin
                    chk("in_ready_during_emit", int'(in_ready), 0);
                    chk("out_not_positive", (out_data <= 0) ? 1 : 0, 1);
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_output", int'(out_data), 999999);
                    end else begin
                        e = sb.pop_front();
                        chk("out_data", int'(out_data), e.data);
                        chk("out_last", int'(out_last), int'(e.last));
                    end
                end
                if (in_valid && in_ready) begin
                    acc_edge = cyc + 1;
                end
                pv = out_valid;
                ps = out_valid && !out_ready;
                pd = int'(out_data);
                pl = out_last;
            end
        end
    end

    function automatic int clamp_len(input int l);
        if (l == 0) return 1;
        if (l > LMAX) return LMAX;
        return l;
    endfunction

    task automatic fill_random(input bit narrow);
        logic signed [DW-1:0] t;
        for (int i = 0; i < LMAX; i++) begin
            if (narrow) begin
                rv[i] = int'($urandom_range(0, 4000)) - 2000;
            end else begin
                t = DW'($urandom());
                rv[i] = int'(t);
            end
        end
    endtask

    // Drive n beats from rv[]; row_len is meaningful only on the first beat.
    task automatic drive_beats(input int len_field, input int n, input bit gaps);
        int  w;
        bit  got;
        for (int i = 0; i < n; i++) begin
            if (gaps && i > 0 && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = DW'(rv[i]);
            row_len  = (i == 0) ? RLW'(len_field) : RLW'($urandom());
            w   = 0;
            got = 1'b0;
            while (!got && w < 3000) begin
                @(negedge clk);
                if (in_ready === 1'b1) got = 1'b1;
                w++;
            end
            if (!got) begin
                chk("accept_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Reference: out[i] = max(x[i] - max(x), SAT_MIN); last on the final element.
    task automatic send_row(input int len_field, input bit gaps);
        int   l;
        int   mx;
        int   d;
        exp_t e;
        l  = clamp_len(len_field);
        mx = rv[0];
        for (int i = 1; i < l; i++) begin
            if (rv[i] > mx) mx = rv[i];
        end
        for (int i = 0; i < l; i++) begin
            d = rv[i] - mx;
            e.data = (d < SATV) ? SATV : d;
            e.last = (i == l - 1);
            sb.push_back(e);
        end
        drive_beats(len_field, l, gaps);
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        in_valid = 1'b0;
        while ((sb.size() != 0 || busy !== 1'b0 || out_valid !== 1'b0) && w < 5000) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("drain_sb_empty", sb.size(), 0);
        chk("drain_busy", int'(busy), 0);
        chk("idle_in_ready", int'(in_ready), 1);
    endtask

    task automatic wait_out_valid();
        int w;
        w = 0;
        while (out_valid !== 1'b1 && w < 500) begin
            @(negedge clk);
            w++;
        end
        chk("out_valid_seen", int'(out_valid), 1);
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset away from any clock edge; outputs must clear at once.
    task automatic async_reset_check(input string tag);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_out_data"}, int'(out_data), 0);
        chk({tag, "_out_last"}, int'(out_last), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_in_ready"}, int'(in_ready), 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        row_len  = '0;
        @(posedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed row of four.
        rv[0] = 1024; rv[1] = -2048; rv[2] = 3072; rv[3] = 0;
        send_row(4, 1'b0);
        wait_drain();

        // Negative saturation.
        rv[0] = 131071; rv[1] = -131072;
        send_row(2, 1'b0);
        wait_drain();

        // Equal values with a mid-row downstream stall.
        rv[0] = -500; rv[1] = -500; rv[2] = -500;
        send_row(3, 1'b0);
        wait_out_valid();
        rdy_mode = 2;
        repeat (3) @(posedge clk);
        #1;
        rdy_mode = 0;
        wait_drain();

        // Two full rows back to back, in_valid held high across EMIT.
        rdy_mode = 1;
        fill_random(1'b0);
        send_row(64, 1'b0);
        fill_random(1'b0);
        send_row(64, 1'b0);
        wait_drain();

        // Length clamping.
        rdy_mode = 0;
        fill_random(1'b0);
        send_row(0, 1'b0);
        wait_drain();
        fill_random(1'b1);
        send_row(100, 1'b0);
        wait_drain();

        // Abort mid-LOAD, then mid-EMIT.
        fill_random(1'b0);
        drive_beats(5, 3, 1'b0);
        chk("busy_in_load", int'(busy), 1);
        async_reset_check("rst_load");
        rdy_mode = 1;
        fill_random(1'b0);
        send_row(6, 1'b0);
        wait_out_valid();
        chk("busy_in_emit", int'(busy), 1);
        async_reset_check("rst_emit");
        rdy_mode = 0;
        rv[0] = 10; rv[1] = 20;
        send_row(2, 1'b0);
        wait_drain();

        // Random rows: random lengths (including clamped), gaps and backpressure.
        rdy_mode = 1;
        for (int r = 0; r < 20; r++) begin
            fill_random(r[0]);
            send_row(int'($urandom_range(0, 127)), 1'b1);
            if (r[1]) wait_drain();
        end
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/softmax_max_sub.md
Name: softmax_max_sub

Overview:
Softmax front-end stage that sits directly upstream of the exponent unit.
- Buffers one row of attention scores (S7Q10) and tracks the row maximum while loading.
- Replays the row as x - max, saturated to S7Q10, so every value delivered to the exp stage is <= 0.
- Uses ready/valid on both sides; the downstream normalizer supplies out_ready.

Parameters:
DATA_W, 18, score width (signed, 10 fractional bits)
ROW_LEN_MAX, 64, maximum row length held in the buffer
ADDR_W, 6, log2(ROW_LEN_MAX)

Ports:
clk  input  1  single clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
row_len  input  ADDR_W+1  row length; sampled only on the first accepted beat of a row
in_valid  input  1  upstream score valid
in_ready  output  1  stage accepts a score this cycle
in_data  input  DATA_W  signed S7Q10 score
out_valid  output  1  out_data is valid
out_ready  input  1  downstream accepts out_data
out_data  output  DATA_W  signed S7Q10 value, x - row_max, always <= 0
out_last  output  1  qualifies the final element of the row
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=0, out_valid=0, out_data=0, out_last=0, busy=0; counters cleared; max cleared. Buffer contents are don't-care. Asserting rst_n low mid-row discards the partial row. No output is produced for it.
- FSM states IDLE, LOAD, EMIT.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch len = clamp(row_len) (0 -> 1, >ROW_LEN_MAX -> ROW_LEN_MAX); write buf[0]; max=in_data; wr_cnt=1.
  - If len==1 go to EMIT, else go to LOAD.
- LOAD:
  - in_ready=1.
  - Each accepted beat: buf[wr_cnt]=in_data; max=(in_data>max)?in_data:max (signed compare); wr_cnt++.
  - The beat that makes wr_cnt==len moves to EMIT on the next edge.
  - Gaps in in_valid are allowed.
- EMIT:
  - in_ready=0.
  - Output register loads when (!out_valid || out_ready) and rd_cnt<len: out_data=sat(buf[rd_cnt]-max); out_last=(rd_cnt==len-1); out_valid=1; rd_cnt++.
  - out_valid rises on the first cycle in EMIT, i.e. 1 cycle after the edge that accepted the last input.
  - Throughput is one element per cycle while out_ready=1.
  - When the handshake with out_last=1 completes: out_valid=0, out_last=0, rd_cnt=0, go to IDLE. in_ready returns to 1 the following cycle.
- Backpressure: while out_valid && !out_ready, out_data, out_last and out_valid hold stable.
- Arithmetic:
  - Difference is computed at DATA_W+1 bits signed; range is [-(2^DATA_W-1), 0].
  - Values below -2^(DATA_W-1) saturate to -2^(DATA_W-1) (-131072).
  - No positive overflow is possible.
- Row length covers one full buffer; the next row cannot load until the current row has fully drained (no ping-pong).
- Simultaneous events: in_valid during EMIT is ignored (in_ready=0); the upstream must hold its data.

Decomposition:
- Shared softmax package holds:
  - DATA_W and the S7Q10 fraction-bit constant (10);
  - SAT_MIN = -2^(DATA_W-1);
  - the FSM state enum {IDLE, LOAD, EMIT}.
- One natural sub-module, softmax_row_buf: ROW_LEN_MAX x DATA_W register array with a single write port and an asynchronous read port (no reset on storage).
- The max tracker, FSM and subtract/saturate output register live in the top module.

Test Plan:
- row_len=4, in_data 1024, -2048, 3072, 0 -> out_data -2048, -5120, 0, -3072; out_last on the 4th only; first out_valid 1 cycle after last input accept.
- row_len=2, in_data 131071, -131072 -> out_data 0, -131072 (saturated from -262143).
- row_len=3, all inputs -500 with out_ready low for 3 cycles mid-row -> three outputs of 0; out_data and out_last stable while stalled; no element lost or duplicated.
- row_len=64 random values, two back-to-back rows, in_valid held high -> in_ready=0 throughout EMIT; second row's outputs use its own max; every output <= 0 and equals a reference model.
- row_len=0, then row_len=100 -> treated as 1 (single output 0 with out_last=1) and as 64 respectively.
- rst_n pulsed low asynchronously mid-LOAD and again mid-EMIT -> outputs go 0 immediately; busy=0; next row of 2 values (10, 20) yields -10, 0 with no residue from the aborted row.
